// File: rtl/vx_gbar_ctrl.sv
// Global barrier controller: round-robin accepts one barrier arrival per cycle,
// counts arrivals per barrier ID and broadcasts a one-cycle release pulse.
module vx_gbar_ctrl #(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int SIZE_W       = 4,
  localparam int BAR_W       = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS*BAR_W-1:0]  req_id,
  input  logic [NUM_REQS*SIZE_W-1:0] req_size_m1,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic                       rsp_valid,
  output logic [BAR_W-1:0]           rsp_id,
  output logic                       err,
  output logic                       busy
);

  localparam int RR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [BAR_W:0] NB_LIM = (BAR_W+1)'(NUM_BARRIERS);

  logic [SIZE_W:0]          cnt  [NUM_BARRIERS];
  logic [SIZE_W-1:0]        size [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0]  active;
  logic [NUM_BARRIERS-1:0]  active_nxt;
  logic [RR_W-1:0]          rr;
  logic [RR_W-1:0]          rr_nxt;
  logic [RR_W-1:0]          gnt_idx;
  logic [2*NUM_REQS-1:0]    dbl;
  logic                     found;
  int                       off_sel;
  int                       gnt_sum;
  int                       rr_sum;
  logic                     acc;
  logic                     hit;
  logic                     in_range;
  logic [BAR_W-1:0]         sel_id;
  logic [SIZE_W-1:0]        sel_size;
  logic [SIZE_W:0]          cur_cnt;
  logic [SIZE_W-1:0]        cur_size;
  logic                     cur_act;
  logic                     first;
  logic [SIZE_W-1:0]        eff_size;
  logic [SIZE_W:0]          new_cnt;
  logic                     fin;
  logic                     mismatch;

  // Rotating the doubled request vector by rr turns "first valid at or after rr"
  // into "lowest set bit", avoiding a variable-indexed search.
  always_comb begin
    dbl     = {req_valid, req_valid} >> rr;
    found   = 1'b0;
    off_sel = 0;
    for (int off = 0; off < NUM_REQS; off++) begin
      if (!found && dbl[off]) begin
        found   = 1'b1;
        off_sel = off;
      end
    end
    gnt_sum = int'(rr) + off_sel;
    if (gnt_sum >= NUM_REQS) gnt_sum = gnt_sum - NUM_REQS;
    gnt_idx = RR_W'(gnt_sum);
    rr_sum  = gnt_sum + 1;
    if (rr_sum >= NUM_REQS) rr_sum = 0;
    rr_nxt  = RR_W'(rr_sum);
    acc     = reset && found;

    req_ready = '0;
    sel_id    = '0;
    sel_size  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = acc && (gnt_idx == RR_W'(i));
      if (gnt_idx == RR_W'(i)) begin
        sel_id   = req_id[i*BAR_W +: BAR_W];
        sel_size = req_size_m1[i*SIZE_W +: SIZE_W];
      end
    end
    in_range = {1'b0, sel_id} < NB_LIM;
    hit      = acc && in_range;

    cur_cnt  = '0;
    cur_size = '0;
    cur_act  = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (sel_id == BAR_W'(b)) begin
        cur_cnt  = cnt[b];
        cur_size = size[b];
        cur_act  = active[b];
      end
    end

    // A barrier that is not active starts a new generation with this arrival's size.
    first    = !cur_act;
    eff_size = first ? sel_size : cur_size;
    new_cnt  = (first ? '0 : cur_cnt) + (SIZE_W+1)'(1);
    fin      = (new_cnt == ({1'b0, eff_size} + (SIZE_W+1)'(1)));
    mismatch = hit && !first && (sel_size != cur_size);

    active_nxt = active;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if (hit && (sel_id == BAR_W'(b))) active_nxt[b] = !fin;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr        <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      active    <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        cnt[b]  <= '0;
        size[b] <= '0;
      end
    end else begin
      rsp_valid <= hit && fin;
      if (hit && fin) rsp_id <= sel_id;
      if (acc) rr <= rr_nxt;
      if ((acc && !in_range) || mismatch) err <= 1'b1;
      active <= active_nxt;
      busy   <= |active_nxt;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        if (hit && (sel_id == BAR_W'(b))) begin
          cnt[b] <= fin ? '0 : new_cnt;
          if (first && !fin) size[b] <= sel_size;
        end
      end
    end
  end

endmodule
